// File: rtl/wb_pipe_reg.sv
// rtl/wb_pipe_reg.sv - write-back pipeline register chain with stall, flush and operand forwarding
// Stage 0 is the youngest entry; stage DEPTH-1 drives the outputs.
module wb_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              valid_i,
   input  logic              regWen_i,
   input  logic [RD_W-1:0]   rd_i,
   input  logic [DATA_W-1:0] wr_i,
   output logic              valid_o,
   output logic              regWen_o,
   output logic [RD_W-1:0]   rd_o,
   output logic [DATA_W-1:0] wr_o,
   input  logic [RD_W-1:0]   rs1_i,
   input  logic [RD_W-1:0]   rs2_i,
   output logic              fwd1_hit_o,
   output logic              fwd2_hit_o,
   output logic [DATA_W-1:0] fwd1_data_o,
   output logic [DATA_W-1:0] fwd2_data_o,
   output logic [2:0]        occ_o
);

   logic              v_q  [DEPTH];
   logic              we_q [DEPTH];
   logic [RD_W-1:0]   rd_q [DEPTH];
   logic [DATA_W-1:0] wr_q [DEPTH];

   // Writes to x0 are dropped on entry so no later stage ever forwards or commits them.
   logic entry_we;
   assign entry_we = regWen_i & valid_i & (rd_i != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < DEPTH; k++) begin
            v_q[k]  <= 1'b0;
            we_q[k] <= 1'b0;
            rd_q[k] <= '0;
            wr_q[k] <= '0;
         end
      end else if (flush_i) begin
         // Only the qualifiers are killed; payload is left as-is.
         for (int k = 0; k < DEPTH; k++) begin
            v_q[k]  <= 1'b0;
            we_q[k] <= 1'b0;
         end
      end else if (!stall_i) begin
         v_q[0]  <= valid_i;
         we_q[0] <= entry_we;
         rd_q[0] <= rd_i;
         wr_q[0] <= wr_i;
         for (int k = 1; k < DEPTH; k++) begin
            v_q[k]  <= v_q[k-1];
            we_q[k] <= we_q[k-1];
            rd_q[k] <= rd_q[k-1];
            wr_q[k] <= wr_q[k-1];
         end
      end
   end

   assign valid_o  = v_q[DEPTH-1];
   assign regWen_o = we_q[DEPTH-1];
   assign rd_o     = rd_q[DEPTH-1];
   assign wr_o     = wr_q[DEPTH-1];

   // Scan oldest to youngest so the youngest matching stage wins.
   always_comb begin
      fwd1_hit_o  = 1'b0;
      fwd1_data_o = '0;
      fwd2_hit_o  = 1'b0;
      fwd2_data_o = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (v_q[k] && we_q[k] && (rd_q[k] == rs1_i) && (rs1_i != '0)) begin
            fwd1_hit_o  = 1'b1;
            fwd1_data_o = wr_q[k];
         end
         if (v_q[k] && we_q[k] && (rd_q[k] == rs2_i) && (rs2_i != '0)) begin
            fwd2_hit_o  = 1'b1;
            fwd2_data_o = wr_q[k];
         end
      end
   end

   always_comb begin
      occ_o = 3'd0;
      for (int k = 0; k < DEPTH; k++) begin
         occ_o = occ_o + {2'b00, v_q[k]};
      end
   end

endmodule

// File: doc/wb_pipe_reg.md
WB_PIPE_REG -- requirements
Module: wb_pipe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of the write-back data path.
REQ-002 SHALL have parameter RD_W, default 5, meaning width of the destination register index.
REQ-003 SHALL have parameter DEPTH, default 2, legal range 1..4, meaning number of register stages.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 stall_i  input  1  when high, holds every stage.
REQ-007 flush_i  input  1  when high, kills every stage and the incoming entry.
REQ-008 valid_i  input  1  incoming entry present.
REQ-009 regWen_i  input  1  incoming register-write enable.
REQ-010 rd_i  input  RD_W  incoming destination index.
REQ-011 wr_i  input  DATA_W  incoming write-back data.
REQ-012 valid_o  output  1  last stage holds a live entry.
REQ-013 regWen_o  output  1  qualified write enable of last stage.
REQ-014 rd_o  output  RD_W  last-stage destination index.
REQ-015 wr_o  output  DATA_W  last-stage write-back data.
REQ-016 rs1_i, rs2_i  input  RD_W each  forwarding lookup indices.
REQ-017 fwd1_hit_o, fwd2_hit_o  output  1 each  lookup matched a pending write.
REQ-018 fwd1_data_o, fwd2_data_o  output  DATA_W each  forwarded data.
REQ-019 occ_o  output  3  count of stages with valid set (0..DEPTH).

Function
REQ-020 Each stage k (0 = youngest, DEPTH-1 = output) SHALL hold valid, regWen, rd, wr registers.
REQ-021 Stage 0 SHALL capture valid_i, and regWen as regWen_i & valid_i & (rd_i != 0), i.e. writes to x0 are dropped at entry.
REQ-022 With stall_i=0 and flush_i=0, stage k SHALL load stage k-1 each cycle; latency input-to-output is exactly DEPTH cycles.
REQ-023 With stall_i=1 and flush_i=0, all stages SHALL hold; inputs ignored; outputs unchanged.
REQ-024 flush_i=1 SHALL, on the next edge, clear valid and regWen in every stage regardless of stall_i and valid_i (flush has priority); rd and wr registers keep their prior values.
REQ-025 Outputs valid_o, regWen_o, rd_o, wr_o SHALL be driven directly from stage DEPTH-1 registers (no combinational path from inputs).
REQ-026 For each lookup n, a stage matches when valid & regWen & (rd == rsn_i) & (rsn_i != 0).
REQ-027 fwdn_hit_o SHALL be OR of matches; fwdn_data_o SHALL be wr of the lowest-index (youngest) matching stage, else 0.
REQ-028 Forwarding SHALL be combinational from stage registers only; entries at inputs are not forwarded.
REQ-029 rsn_i == 0 SHALL yield hit 0, data 0.
REQ-030 occ_o SHALL equal the population count of stage valid bits, zero-extended.
REQ-031 DEPTH=1 SHALL behave identically to a single pipeline register with the same stall/flush/qualification rules.

Reset
REQ-032 rst_n low SHALL asynchronously clear all valid, regWen, rd, wr registers to 0, so valid_o, regWen_o, rd_o, wr_o, occ_o, all hit and data outputs read 0.
REQ-033 Reset deasserted mid-stream SHALL discard all in-flight entries; first capture occurs on the first rising edge with rst_n high.

Verification
REQ-034 DEPTH=2, inject valid, regWen, rd=7, wr=0xDEADBEEF at cycle 0 -> valid_o/regWen_o=1, rd_o=7, wr_o=0xDEADBEEF at cycle 2 only.
REQ-035 Inject rd=0, regWen=1, wr=0x5 -> regWen_o=0 at output; rs1_i=0 gives fwd1_hit_o=0, data 0.
REQ-036 Stages hold rd=3 (wr=0x11, stage1) and rd=3 (wr=0x22, stage0); rs1_i=3 -> hit 1, data 0x22; advance one cycle with no new input -> data 0x22 from stage1.
REQ-037 Fill both stages, stall_i=1 for 3 cycles with new valid_i -> outputs and occ_o=2 unchanged; release -> original entries exit in order.
REQ-038 Fill both stages, assert stall_i=1 and flush_i=1 together -> next cycle valid_o=0, regWen_o=0, occ_o=0, all hits 0.
REQ-039 Drop rst_n asynchronously between edges with occ_o=2 -> all outputs 0 immediately, before the next clk edge.
